csi2_arbiter_fsm_nch: RTL and testbench
=======================================

// Module: csi2_arbiter_fsm_nch
// PURPOSE
//  N-channel successor of the 2-channel CSI-2 header arbiter. Sits between N header buffers and
//  cmos2dphy in the tx clock domain: selects one pending header (round-robin or fixed priority),
//  presents wdcnt/dtype/VC/SPtype to cmos2dphy, holds the grant until the buffer reports xfrdone,
//  then enforces a minimum LP gap. Adds optional VC remap and a transfer watchdog.
// PARAMETERS
//  NUM_CH     4      number of header-buffer inputs (2..8)
//  RR_MODE    1      1 = round-robin from last winner + 1; 0 = fixed priority, ch0 highest
//  VC_REMAP   0      1 = arb_chID driven with the winning channel index; 0 = pass hdr chID through
//  LP_GAP     4      LP-gap cycles after xfrdone before next grant (>=1)
//  TMO_CYC    65535  watchdog limit in XFER state, cycles; 0 disables the watchdog
//  CW         clog2(NUM_CH) (localparam) channel index width
// PORTS
//  clk_i           in   1          tx byte clock
//  rst_i           in   1          synchronous, active-high reset
//  c2d_rdy         in   1          cmos2dphy idle/ready for a new packet
//  hdr_req         in   NUM_CH     per-channel header pending
//  hdr_wdcnt       in   16*NUM_CH  word count, ch k at [16k+:16]
//  hdr_dtype       in   6*NUM_CH   data type, ch k at [6k+:6]
//  hdr_chID        in   2*NUM_CH   virtual channel, ch k at [2k+:2]
//  hdr_SPtype      in   NUM_CH     1 = short packet, 0 = long packet
//  hdr_rd_lbfr_en  in   NUM_CH     line-buffer read enable (qualifies arb_lp_start)
//  hdr_xfrdone     in   NUM_CH     transfer complete pulse
//  arb_sp_req      out  1          packet request to cmos2dphy, 1-cycle pulse
//  arb_wdcnt       out  16         latched winner word count
//  arb_dtype       out  6          latched winner data type
//  arb_chID        out  2          latched VC (remapped when VC_REMAP=1)
//  arb_SPtype      out  1          latched winner packet type
//  arb_lp_start    out  1          1-cycle pulse on first winner rd_lbfr_en of a long packet
//  arb_gnt         out  NUM_CH     one-hot grant, held GRANT..XFER
//  arb_rdy         out  1          1 only in IDLE
//  arb_c2dreq_o    out  1          level: high REQ..XFER (cmos2dphy ownership)
//  arb_tmo         out  1          1-cycle pulse when watchdog fires
// BEHAVIOUR
//  Reset: state IDLE; arb_gnt=0, arb_sp_req=0, arb_c2dreq_o=0, arb_lp_start=0, arb_tmo=0,
//   arb_rdy=1, arb_wdcnt/dtype/chID/SPtype=0, last-winner pointer = NUM_CH-1 (ch0 wins first in RR).
//  FSM: IDLE -> GRANT when |hdr_req: pick winner, latch its fields, set arb_gnt[w], arb_rdy=0.
//   GRANT -> REQ when c2d_rdy=1 (stays in GRANT otherwise). REQ: arb_sp_req=1 one cycle, c2dreq=1.
//   REQ -> XFER next cycle. XFER -> GAP on hdr_xfrdone[w]; xfrdone of non-winners ignored.
//   GAP counts LP_GAP cycles then -> IDLE; arb_gnt cleared on entry to GAP.
//  Latency: req seen in IDLE at cycle t -> gnt at t+1 -> sp_req at t+2 if c2d_rdy at t+1.
//  Selection: RR searches from (last+1) mod NUM_CH, wraps; pointer updated only on GRANT entry.
//   Fixed mode: lowest index wins. Requests dropping during GRANT do not revoke grant.
//  arb_lp_start: in XFER, long packet only, first cycle hdr_rd_lbfr_en[w]=1; at most once per grant.
//  Watchdog: counter cleared on REQ, increments in XFER; reaching TMO_CYC -> pulse arb_tmo, -> GAP.
//  Simultaneous xfrdone and timeout in same cycle: xfrdone wins, no arb_tmo.
//  Reset mid-transfer: all outputs return to reset values next edge; no sp_req replay.
//  Output fields stable from GRANT until next GRANT; never change while c2dreq high.
// STRUCTURE
//  Package csi2_arb_pkg: state encoding (IDLE,GRANT,REQ,XFER,GAP), field widths WC_W=16, DT_W=6,
//   VC_W=2, SP_SHORT/SP_LONG constants.
//  Sub-module csi2_rr_pick: combinational masked round-robin/fixed-priority picker
//   (req, last_ptr, mode -> one-hot gnt + index). FSM, latches, gap and watchdog counters in top.
// TESTING
//  Single req ch2 (wc=0x0780, dt=0x2B, long), c2d_rdy=1 -> gnt=0100 at t+1, sp_req at t+2, fields match.
//  All 4 req held, RR_MODE=1 -> grant order 0,1,2,3,0; RR_MODE=0 -> 0,0,0 while ch0 held.
//  c2d_rdy low 10 cycles after grant -> stays GRANT, sp_req only after rdy rises, exactly one pulse.
//  xfrdone from ch1 while ch3 granted -> ignored; ch3 xfrdone -> GAP for LP_GAP=4 cycles, then arb_rdy=1.
//  TMO_CYC=16, no xfrdone -> arb_tmo at 16th XFER cycle, gnt cleared; xfrdone same cycle -> no tmo.
//  VC_REMAP=1, ch3 with hdr chID=0 -> arb_chID=3; rst_i in XFER -> all outputs reset next edge.

Source files
------------

// File: rtl/csi2_arb_pkg.sv
// Shared types and constants for the N-channel CSI-2 header arbiter.
package csi2_arb_pkg;

    localparam int WC_W  = 16;
    localparam int DT_W  = 6;
    localparam int VC_W  = 2;
    localparam int CNT_W = 16;

    localparam logic SP_SHORT = 1'b1;
    localparam logic SP_LONG  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_REQ   = 3'd2,
        ST_XFER  = 3'd3,
        ST_GAP   = 3'd4
    } arb_state_e;

    // States in which cmos2dphy is owned by the current winner
    function automatic logic is_owned(input arb_state_e st);
        return (st == ST_REQ) || (st == ST_XFER);
    endfunction

endpackage

// File: rtl/csi2_rr_pick.sv
// Combinational picker: round-robin from last_ptr+1 (wrapping) or fixed
// priority with channel 0 highest. Produces a one-hot grant and its index.
module csi2_rr_pick
    import csi2_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CW     = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CW-1:0]     last_ptr,
    input  logic              rr_mode,
    output logic [NUM_CH-1:0] gnt,
    output logic [CW-1:0]     idx,
    output logic              vld
);

    logic [CW-1:0] start_s;
    logic [CW:0]   cand_s;

    // Search start: one past the last winner in round-robin, channel 0 otherwise
    always_comb begin
        if (!rr_mode) begin
            start_s = '0;
        end else if (last_ptr >= CW'(NUM_CH - 1)) begin
            start_s = '0;
        end else begin
            start_s = last_ptr + CW'(1'b1);
        end
    end

    // Walk the channels from start_s with wrap and take the first requester
    always_comb begin
        gnt    = '0;
        idx    = '0;
        vld    = 1'b0;
        cand_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand_s = {1'b0, start_s} + (CW+1)'(i);
            if (cand_s >= (CW+1)'(NUM_CH)) begin
                cand_s = cand_s - (CW+1)'(NUM_CH);
            end else begin
                cand_s = cand_s;
            end
            if (!vld && req[cand_s[CW-1:0]]) begin
                vld                  = 1'b1;
                idx                  = cand_s[CW-1:0];
                gnt[cand_s[CW-1:0]]  = 1'b1;
            end else begin
                vld = vld;
            end
        end
    end

endmodule

// File: rtl/csi2_arbiter_fsm_nch.sv
// N-channel CSI-2 header arbiter: grants one header buffer at a time to
// cmos2dphy, holds it until xfrdone or watchdog timeout, then waits an LP gap.
module csi2_arbiter_fsm_nch
    import csi2_arb_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int RR_MODE  = 1,
    parameter int VC_REMAP = 0,
    parameter int LP_GAP   = 4,
    parameter int TMO_CYC  = 65535
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     c2d_rdy,
    input  logic [NUM_CH-1:0]        hdr_req,
    input  logic [WC_W*NUM_CH-1:0]   hdr_wdcnt,
    input  logic [DT_W*NUM_CH-1:0]   hdr_dtype,
    input  logic [VC_W*NUM_CH-1:0]   hdr_chID,
    input  logic [NUM_CH-1:0]        hdr_SPtype,
    input  logic [NUM_CH-1:0]        hdr_rd_lbfr_en,
    input  logic [NUM_CH-1:0]        hdr_xfrdone,
    output logic                     arb_sp_req,
    output logic [WC_W-1:0]          arb_wdcnt,
    output logic [DT_W-1:0]          arb_dtype,
    output logic [VC_W-1:0]          arb_chID,
    output logic                     arb_SPtype,
    output logic                     arb_lp_start,
    output logic [NUM_CH-1:0]        arb_gnt,
    output logic                     arb_rdy,
    output logic                     arb_c2dreq_o,
    output logic                     arb_tmo
);

    localparam int   CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic RR_EN  = (RR_MODE != 0);
    localparam logic TMO_EN = (TMO_CYC != 0);

    arb_state_e state_q, state_d;

    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [CW-1:0]     last_q, last_d;
    logic [WC_W-1:0]   wdcnt_q, wdcnt_d;
    logic [DT_W-1:0]   dtype_q, dtype_d;
    logic [VC_W-1:0]   chid_q, chid_d;
    logic              sptype_q, sptype_d;
    logic              sp_req_q, sp_req_d;
    logic              rdy_q, rdy_d;
    logic              c2dreq_q, c2dreq_d;
    logic              lp_start_q, lp_start_d;
    logic              lp_done_q, lp_done_d;
    logic              tmo_q, tmo_d;
    logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;

    logic [NUM_CH-1:0] pick_gnt_s;
    logic [CW-1:0]     pick_idx_s;
    logic              pick_vld_s;
    logic              xfr_hit_s;
    logic              tmo_hit_s;
    logic              gap_done_s;
    logic              grant_entry_s;

    csi2_rr_pick #(
        .NUM_CH (NUM_CH),
        .CW     (CW)
    ) u_pick (
        .req      (hdr_req),
        .last_ptr (last_q),
        .rr_mode  (RR_EN),
        .gnt      (pick_gnt_s),
        .idx      (pick_idx_s),
        .vld      (pick_vld_s)
    );

    // gnt_q is one-hot on the winner, so masking isolates the winner's done
    assign xfr_hit_s     = |(hdr_xfrdone & gnt_q);
    assign tmo_hit_s     = TMO_EN && (({1'b0, wd_cnt_q} + 17'd1) == 17'(TMO_CYC));
    assign gap_done_s    = (gap_cnt_q == CNT_W'(LP_GAP - 1));
    assign grant_entry_s = (state_q == ST_IDLE) && (state_d == ST_GRANT);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; xfrdone takes precedence over a coincident timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (c2d_rdy) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_REQ: begin
                state_d = ST_XFER;
            end
            ST_XFER: begin
                if (xfr_hit_s || tmo_hit_s) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_GAP: begin
                if (gap_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values; all outputs are registered from these
    always_comb begin
        gnt_d    = gnt_q;
        last_d   = last_q;
        wdcnt_d  = wdcnt_q;
        dtype_d  = dtype_q;
        chid_d   = chid_q;
        sptype_d = sptype_q;
        if (grant_entry_s) begin
            gnt_d    = pick_gnt_s;
            last_d   = pick_idx_s;
            wdcnt_d  = hdr_wdcnt[pick_idx_s*WC_W +: WC_W];
            dtype_d  = hdr_dtype[pick_idx_s*DT_W +: DT_W];
            sptype_d = hdr_SPtype[pick_idx_s];
            if (VC_REMAP != 0) begin
                chid_d = VC_W'(pick_idx_s);
            end else begin
                chid_d = hdr_chID[pick_idx_s*VC_W +: VC_W];
            end
        end else if ((state_d == ST_GRANT) || is_owned(state_d)) begin
            gnt_d = gnt_q;
        end else begin
            gnt_d = '0;
        end

        rdy_d    = (state_d == ST_IDLE);
        sp_req_d = (state_d == ST_REQ);
        c2dreq_d = is_owned(state_d);
        // The timeout pulse lands together with the gnt drop on GAP entry
        tmo_d    = (state_q == ST_XFER) && !xfr_hit_s && tmo_hit_s;

        lp_start_d = (state_q == ST_XFER) && (sptype_q == SP_LONG) &&
                     (|(hdr_rd_lbfr_en & gnt_q)) && !lp_done_q;
        if (grant_entry_s) begin
            lp_done_d = 1'b0;
        end else begin
            lp_done_d = lp_done_q | lp_start_d;
        end

        if (state_q == ST_XFER) begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1'b1);
        end else begin
            wd_cnt_d = '0;
        end
        if (state_q == ST_GAP) begin
            gap_cnt_d = gap_cnt_q + CNT_W'(1'b1);
        end else begin
            gap_cnt_d = '0;
        end
    end

    // Output and datapath registers; last_q resets so that ch0 wins first
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_q      <= '0;
            last_q     <= CW'(NUM_CH - 1);
            wdcnt_q    <= '0;
            dtype_q    <= '0;
            chid_q     <= '0;
            sptype_q   <= 1'b0;
            sp_req_q   <= 1'b0;
            rdy_q      <= 1'b1;
            c2dreq_q   <= 1'b0;
            lp_start_q <= 1'b0;
            lp_done_q  <= 1'b0;
            tmo_q      <= 1'b0;
            wd_cnt_q   <= '0;
            gap_cnt_q  <= '0;
        end else begin
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            wdcnt_q    <= wdcnt_d;
            dtype_q    <= dtype_d;
            chid_q     <= chid_d;
            sptype_q   <= sptype_d;
            sp_req_q   <= sp_req_d;
            rdy_q      <= rdy_d;
            c2dreq_q   <= c2dreq_d;
            lp_start_q <= lp_start_d;
            lp_done_q  <= lp_done_d;
            tmo_q      <= tmo_d;
            wd_cnt_q   <= wd_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign arb_gnt      = gnt_q;
    assign arb_wdcnt    = wdcnt_q;
    assign arb_dtype    = dtype_q;
    assign arb_chID     = chid_q;
    assign arb_SPtype   = sptype_q;
    assign arb_sp_req   = sp_req_q;
    assign arb_rdy      = rdy_q;
    assign arb_c2dreq_o = c2dreq_q;
    assign arb_lp_start = lp_start_q;
    assign arb_tmo      = tmo_q;

endmodule

// File: tb/tb_csi2_arbiter_fsm_nch.sv
// Scoreboard bench: a remapping round-robin arbiter with a 16-cycle watchdog,
// plus a fixed-priority pass-through instance with all requests held.
module tb_csi2_arbiter_fsm_nch;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_i;
    logic            c2d_rdy;
    logic [N-1:0]    hdr_req, hdr_sptype, hdr_rd_lbfr_en, hdr_xfrdone;
    logic [16*N-1:0] hdr_wdcnt;
    logic [6*N-1:0]  hdr_dtype;
    logic [2*N-1:0]  hdr_chid;
    logic            arb_sp_req, arb_sptype, arb_lp_start, arb_rdy, arb_c2dreq_o, arb_tmo;
    logic [15:0]     arb_wdcnt;
    logic [5:0]      arb_dtype;
    logic [1:0]      arb_chid;
    logic [N-1:0]    arb_gnt;

    logic [N-1:0]    fp_req, fp_sptype, fp_lbfr, fp_done;
    logic [16*N-1:0] fp_wdcnt;
    logic [6*N-1:0]  fp_dtype;
    logic [2*N-1:0]  fp_chid_in;
    logic            fp_sp_req, fp_sptype_o, fp_lp_start, fp_rdy, fp_c2dreq, fp_tmo;
    logic [15:0]     fp_wdcnt_o;
    logic [5:0]      fp_dtype_o;
    logic [1:0]      fp_chid_o;
    logic [N-1:0]    fp_gnt;

    csi2_arbiter_fsm_nch #(.NUM_CH(N), .RR_MODE(1), .VC_REMAP(1), .LP_GAP(4), .TMO_CYC(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .c2d_rdy(c2d_rdy), .hdr_req(hdr_req),
        .hdr_wdcnt(hdr_wdcnt), .hdr_dtype(hdr_dtype), .hdr_chID(hdr_chid),
        .hdr_SPtype(hdr_sptype), .hdr_rd_lbfr_en(hdr_rd_lbfr_en), .hdr_xfrdone(hdr_xfrdone),
        .arb_sp_req(arb_sp_req), .arb_wdcnt(arb_wdcnt), .arb_dtype(arb_dtype),
        .arb_chID(arb_chid), .arb_SPtype(arb_sptype), .arb_lp_start(arb_lp_start),
        .arb_gnt(arb_gnt), .arb_rdy(arb_rdy), .arb_c2dreq_o(arb_c2dreq_o), .arb_tmo(arb_tmo)
    );

    csi2_arbiter_fsm_nch #(.NUM_CH(N), .RR_MODE(0), .VC_REMAP(0), .LP_GAP(4), .TMO_CYC(8)) dut_fp (
        .clk_i(clk), .rst_i(rst_i), .c2d_rdy(1'b1), .hdr_req(fp_req),
        .hdr_wdcnt(fp_wdcnt), .hdr_dtype(fp_dtype), .hdr_chID(fp_chid_in),
        .hdr_SPtype(fp_sptype), .hdr_rd_lbfr_en(fp_lbfr), .hdr_xfrdone(fp_done),
        .arb_sp_req(fp_sp_req), .arb_wdcnt(fp_wdcnt_o), .arb_dtype(fp_dtype_o),
        .arb_chID(fp_chid_o), .arb_SPtype(fp_sptype_o), .arb_lp_start(fp_lp_start),
        .arb_gnt(fp_gnt), .arb_rdy(fp_rdy), .arb_c2dreq_o(fp_c2dreq), .arb_tmo(fp_tmo)
    );

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [15:0]  wc;
        logic [5:0]   dt;
        logic [1:0]   vc;
        logic         sp;
    } exp_t;

    exp_t sb_q[$];
    exp_t fp_q[$];
    exp_t mon_e, fp_e;
    int   total = 0;
    int   bad = 0;
    int   sp_cnt = 0;
    int   snap;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Load one channel's header fields and queue the grant we expect for it
    task automatic load_hdr(input int ch, input logic [15:0] wc, input logic [5:0] dt,
                            input logic [1:0] vc_in, input logic sp);
        exp_t e;
        hdr_wdcnt[16*ch +: 16] = wc;
        hdr_dtype[6*ch +: 6]   = dt;
        hdr_chid[2*ch +: 2]    = vc_in;
        hdr_sptype[ch]         = sp;
        e.gnt = 4'b0001 << ch;
        e.wc  = wc;
        e.dt  = dt;
        e.vc  = 2'(ch);
        e.sp  = sp;
        sb_q.push_back(e);
    endtask

    task automatic wait_sp(input int budget);
        logic hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (arb_sp_req) begin
                hit = 1'b1;
                break;
            end
        end
        check_eq("sp_wait", 32'(hit), 32'd1);
    endtask

    task automatic wait_rdy(input int budget);
        logic hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (arb_rdy) begin
                hit = 1'b1;
                break;
            end
        end
        check_eq("rdy_wait", 32'(hit), 32'd1);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_gnt"}, 32'(arb_gnt), 32'd0);
        check_eq({tag, "_sp"}, 32'(arb_sp_req), 32'd0);
        check_eq({tag, "_c2d"}, 32'(arb_c2dreq_o), 32'd0);
        check_eq({tag, "_lp"}, 32'(arb_lp_start), 32'd0);
        check_eq({tag, "_tmo"}, 32'(arb_tmo), 32'd0);
        check_eq({tag, "_rdy"}, 32'(arb_rdy), 32'd1);
        check_eq({tag, "_wc"}, 32'(arb_wdcnt), 32'd0);
        check_eq({tag, "_dt"}, 32'(arb_dtype), 32'd0);
        check_eq({tag, "_vc"}, 32'(arb_chid), 32'd0);
        check_eq({tag, "_spt"}, 32'(arb_sptype), 32'd0);
    endtask

    always @(negedge clk) begin
        if (arb_sp_req) begin
            sp_cnt++;
            check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check_eq("sb_gnt", 32'(arb_gnt), 32'(mon_e.gnt));
                check_eq("sb_wc", 32'(arb_wdcnt), 32'(mon_e.wc));
                check_eq("sb_dt", 32'(arb_dtype), 32'(mon_e.dt));
                check_eq("sb_vc", 32'(arb_chid), 32'(mon_e.vc));
                check_eq("sb_spt", 32'(arb_sptype), 32'(mon_e.sp));
                check_eq("sb_c2d", 32'(arb_c2dreq_o), 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (fp_sp_req && (fp_q.size() != 0)) begin
            fp_e = fp_q.pop_front();
            check_eq("fp_gnt", 32'(fp_gnt), 32'(fp_e.gnt));
            check_eq("fp_vc", 32'(fp_chid_o), 32'(fp_e.vc));
            check_eq("fp_wc", 32'(fp_wdcnt_o), 32'(fp_e.wc));
            check_eq("fp_dt", 32'(fp_dtype_o), 32'(fp_e.dt));
            check_eq("fp_rdy", 32'(fp_rdy), 32'd0);
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        exp_t fe;
        rst_i = 1'b1;
        c2d_rdy = 1'b1;
        hdr_req = '0; hdr_sptype = '0; hdr_rd_lbfr_en = '0; hdr_xfrdone = '0;
        hdr_wdcnt = '0; hdr_dtype = '0; hdr_chid = '0;
        fp_req = 4'b1111; fp_sptype = '0; fp_lbfr = '0; fp_done = '0;
        fp_wdcnt = {16'h4444, 16'h3333, 16'h2222, 16'hABCD};
        fp_dtype = {6'h04, 6'h03, 6'h02, 6'h2B};
        fp_chid_in = {2'b01, 2'b01, 2'b11, 2'b10};
        fe.gnt = 4'b0001; fe.wc = 16'hABCD; fe.dt = 6'h2B; fe.vc = 2'b10; fe.sp = 1'b0;
        for (int i = 0; i < 3; i++) fp_q.push_back(fe);

        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_i = 1'b0;
        @(negedge clk);

        // Single long request on ch2: gnt at t+1, sp_req at t+2, lp_start once
        load_hdr(2, 16'h0780, 6'h2B, 2'd1, 1'b0);
        hdr_req = 4'b0100;
        @(negedge clk);
        check_eq("t1_gnt", 32'(arb_gnt), 32'h4);
        check_eq("t1_rdy", 32'(arb_rdy), 32'd0);
        check_eq("t1_sp_early", 32'(arb_sp_req), 32'd0);
        hdr_req = '0;
        @(negedge clk);
        check_eq("t1_sp", 32'(arb_sp_req), 32'd1);
        @(negedge clk);
        check_eq("t1_sp_pulse", 32'(arb_sp_req), 32'd0);
        check_eq("t1_c2d", 32'(arb_c2dreq_o), 32'd1);
        hdr_rd_lbfr_en = 4'b0100;
        @(negedge clk);
        check_eq("t1_lp", 32'(arb_lp_start), 32'd1);
        @(negedge clk);
        check_eq("t1_lp_once", 32'(arb_lp_start), 32'd0);
        hdr_xfrdone = 4'b0100;
        @(negedge clk);
        hdr_xfrdone = '0;
        hdr_rd_lbfr_en = '0;
        check_eq("t1_gap_gnt", 32'(arb_gnt), 32'd0);
        check_eq("t1_gap_c2d", 32'(arb_c2dreq_o), 32'd0);
        check_eq("t1_gap_tmo", 32'(arb_tmo), 32'd0);
        check_eq("t1_hold_wc", 32'(arb_wdcnt), 32'h0780);
        repeat (3) @(negedge clk);
        check_eq("t1_gap_len", 32'(arb_rdy), 32'd0);
        @(negedge clk);
        check_eq("t1_gap_end", 32'(arb_rdy), 32'd1);

        // c2d_rdy low for 10 cycles: grant holds, exactly one sp_req afterwards
        c2d_rdy = 1'b0;
        load_hdr(0, 16'h0010, 6'h12, 2'd3, 1'b1);
        hdr_req = 4'b0001;
        @(negedge clk);
        hdr_req = '0;
        snap = sp_cnt;
        repeat (10) @(negedge clk);
        check_eq("t2_hold_gnt", 32'(arb_gnt), 32'h1);
        check_eq("t2_no_sp", 32'(sp_cnt), 32'(snap));
        check_eq("t2_no_c2d", 32'(arb_c2dreq_o), 32'd0);
        c2d_rdy = 1'b1;
        @(negedge clk);
        check_eq("t2_sp", 32'(arb_sp_req), 32'd1);
        hdr_rd_lbfr_en = 4'b0001;
        repeat (3) @(negedge clk);
        check_eq("t2_one_pulse", 32'(sp_cnt), 32'(snap + 1));
        check_eq("t2_no_lp_short", 32'(arb_lp_start), 32'd0);
        hdr_rd_lbfr_en = '0;
        hdr_xfrdone = 4'b0001;
        @(negedge clk);
        hdr_xfrdone = '0;
        wait_rdy(10);

        // ch3 granted with VC remap; ch1 xfrdone ignored, ch3 xfrdone ends it
        load_hdr(3, 16'h1234, 6'h2A, 2'd0, 1'b0);
        hdr_req = 4'b1000;
        @(negedge clk);
        hdr_req = '0;
        wait_sp(5);
        @(negedge clk);
        hdr_xfrdone = 4'b0010;
        @(negedge clk);
        check_eq("t3_ignore_gnt", 32'(arb_gnt), 32'h8);
        check_eq("t3_ignore_c2d", 32'(arb_c2dreq_o), 32'd1);
        hdr_xfrdone = 4'b1000;
        @(negedge clk);
        hdr_xfrdone = '0;
        check_eq("t3_done_gnt", 32'(arb_gnt), 32'd0);
        wait_rdy(10);

        // All four held in round-robin: expect 0,1,2,3,0
        for (int k = 0; k < 4; k++)
            load_hdr(k, 16'h0100 + 16'(k), 6'h10 + 6'(k), 2'(3 - k), 1'b1);
        sb_q.push_back(sb_q[0]);
        hdr_req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_sp(20);
            if (g == 4) hdr_req = '0;
            @(negedge clk);
            hdr_xfrdone = 4'b1111;
            @(negedge clk);
            hdr_xfrdone = '0;
        end
        wait_rdy(10);

        // Watchdog: no xfrdone, timeout after the 16th XFER cycle
        load_hdr(1, 16'h0200, 6'h2B, 2'd2, 1'b0);
        hdr_req = 4'b0010;
        @(negedge clk);
        hdr_req = '0;
        wait_sp(5);
        repeat (16) @(negedge clk);
        check_eq("t5_tmo_early", 32'(arb_tmo), 32'd0);
        check_eq("t5_xfer_gnt", 32'(arb_gnt), 32'h2);
        @(negedge clk);
        check_eq("t5_tmo", 32'(arb_tmo), 32'd1);
        check_eq("t5_tmo_gnt", 32'(arb_gnt), 32'd0);
        check_eq("t5_tmo_c2d", 32'(arb_c2dreq_o), 32'd0);
        @(negedge clk);
        check_eq("t5_tmo_pulse", 32'(arb_tmo), 32'd0);
        wait_rdy(10);

        // xfrdone in the same cycle the watchdog would fire: no timeout
        load_hdr(2, 16'h0300, 6'h30, 2'd1, 1'b1);
        hdr_req = 4'b0100;
        @(negedge clk);
        hdr_req = '0;
        wait_sp(5);
        repeat (16) @(negedge clk);
        hdr_xfrdone = 4'b0100;
        @(negedge clk);
        hdr_xfrdone = '0;
        check_eq("t6_no_tmo", 32'(arb_tmo), 32'd0);
        check_eq("t6_gnt", 32'(arb_gnt), 32'd0);
        @(negedge clk);
        check_eq("t6_no_tmo_late", 32'(arb_tmo), 32'd0);
        wait_rdy(10);

        // Reset in XFER: outputs back to reset, no replay, ch0 wins first again
        load_hdr(0, 16'h0400, 6'h2C, 2'd2, 1'b0);
        hdr_req = 4'b0001;
        @(negedge clk);
        hdr_req = '0;
        wait_sp(5);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check_reset("xrst");
        snap = sp_cnt;
        rst_i = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("t7_no_replay", 32'(sp_cnt), 32'(snap));
        for (int k = 0; k < 4; k++) begin
            hdr_wdcnt[16*k +: 16] = 16'h0500 + 16'(k);
            hdr_dtype[6*k +: 6]   = 6'h20 + 6'(k);
            hdr_sptype[k]         = 1'b1;
        end
        load_hdr(0, 16'h0500, 6'h20, 2'd1, 1'b1);
        hdr_req = 4'b1111;
        @(negedge clk);
        hdr_req = '0;
        wait_sp(5);
        @(negedge clk);
        hdr_xfrdone = 4'b1111;
        @(negedge clk);
        hdr_xfrdone = '0;
        wait_rdy(10);

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        check_eq("fp_drained", 32'(fp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
